// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit accumulator CPU sequencer.
//   - state_e    : sequencer states
//   - OP_*       : 4-bit opcodes (instruction bits [7:4])
//   - OC_*       : alu operation codes driven on alu_oc_o
package cpu_pkg;

  localparam int OPC_W = 4;
  localparam int OC_W  = 3;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    OPERAND = 3'd2,
    EXECUTE = 3'd3,
    STORE   = 3'd4,
    HALT    = 3'd5
  } state_e;

  localparam logic [OPC_W-1:0] OP_NOP   = 4'b0000;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'b0001;
  localparam logic [OPC_W-1:0] OP_AND   = 4'b0010;
  localparam logic [OPC_W-1:0] OP_OR    = 4'b0011;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'b0100;
  localparam logic [OPC_W-1:0] OP_ADD1  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_SUB1  = 4'b0110;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'b0111;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'b1000;
  localparam logic [OPC_W-1:0] OP_STORE = 4'b1001;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'b1010;
  localparam logic [OPC_W-1:0] OP_JZ    = 4'b1011;
  localparam logic [OPC_W-1:0] OP_JC    = 4'b1100;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'b1111;

  localparam logic [OC_W-1:0] OC_NONE = 3'b000;
  localparam logic [OC_W-1:0] OC_XOR  = 3'b001;
  localparam logic [OC_W-1:0] OC_AND  = 3'b010;
  localparam logic [OC_W-1:0] OC_OR   = 3'b011;
  localparam logic [OC_W-1:0] OC_ADD  = 3'b100;
  localparam logic [OC_W-1:0] OC_ADD1 = 3'b101;
  localparam logic [OC_W-1:0] OC_SUB1 = 3'b110;
  localparam logic [OC_W-1:0] OC_SUB  = 3'b111;

endpackage

// File: rtl/cpu_control_unit_decoder.sv
// Combinational opcode classifier for the CPU sequencer.
// Ports:
//   opcode_i        : instruction bits [7:4]
//   needs_operand_o : instruction reads mem[operand] before executing
//   is_alu_o        : instruction writes acc/flags from the alu
//   is_load_o       : LOAD
//   is_jump_o       : JMP / JZ / JC
//   is_store_o      : STORE
//   is_halt_o       : HALT
//   alu_oc_o        : alu operation for alu-class opcodes, OC_NONE otherwise
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output logic             needs_operand_o,
  output logic             is_alu_o,
  output logic             is_load_o,
  output logic             is_jump_o,
  output logic             is_store_o,
  output logic             is_halt_o,
  output logic [OC_W-1:0]  alu_oc_o
);

  always_comb begin
    needs_operand_o = 1'b0;
    is_alu_o        = 1'b0;
    is_load_o       = 1'b0;
    is_jump_o       = 1'b0;
    is_store_o      = 1'b0;
    is_halt_o       = 1'b0;
    alu_oc_o        = OC_NONE;
    unique case (opcode_i)
      OP_XOR:   begin is_alu_o = 1'b1; needs_operand_o = 1'b1; alu_oc_o = OC_XOR; end
      OP_AND:   begin is_alu_o = 1'b1; needs_operand_o = 1'b1; alu_oc_o = OC_AND; end
      OP_OR:    begin is_alu_o = 1'b1; needs_operand_o = 1'b1; alu_oc_o = OC_OR;  end
      OP_ADD:   begin is_alu_o = 1'b1; needs_operand_o = 1'b1; alu_oc_o = OC_ADD; end
      OP_SUB:   begin is_alu_o = 1'b1; needs_operand_o = 1'b1; alu_oc_o = OC_SUB; end
      // Increment/decrement use a constant b, so no operand fetch.
      OP_ADD1:  begin is_alu_o = 1'b1; alu_oc_o = OC_ADD1; end
      OP_SUB1:  begin is_alu_o = 1'b1; alu_oc_o = OC_SUB1; end
      OP_LOAD:  begin is_load_o = 1'b1; needs_operand_o = 1'b1; end
      OP_STORE: is_store_o = 1'b1;
      OP_JMP, OP_JZ, OP_JC: is_jump_o = 1'b1;
      OP_HALT:  is_halt_o = 1'b1;
      // NOP, 1101 and 1110 fall through as no-ops.
      default:  ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for the 4-bit accumulator CPU. Fetches instructions
// over a req/ready memory port, decodes them, drives the external alu and
// holds the architectural state (pc, acc, carry, zero).
// Ports:
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   mem_req_o/we_o/addr_o    : memory request, direction, address
//   mem_wdata_o              : store data {0, acc}
//   mem_rdata_i, mem_ready_i : read data, transfer-complete strobe
//   alu_a_o/b_o/oc_o         : alu operands and operation
//   alu_result_i/carry_i     : alu result and carry/borrow
//   acc_o, pc_o              : accumulator, program counter
//   carry_o, zero_o          : registered flags
//   halted_o                 : high while in HALT
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH           = 4,
  parameter int ADDR_WIDTH           = 4,
  parameter int INSTR_WIDTH          = 8,
  parameter int OPERATION_CODE_WIDTH = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic [INSTR_WIDTH-1:0]          mem_wdata_o,
  input  logic [INSTR_WIDTH-1:0]          mem_rdata_i,
  input  logic                            mem_ready_i,
  output logic [DATA_WIDTH-1:0]           alu_a_o,
  output logic [DATA_WIDTH-1:0]           alu_b_o,
  output logic [OPERATION_CODE_WIDTH-1:0] alu_oc_o,
  input  logic [DATA_WIDTH-1:0]           alu_result_i,
  input  logic                            alu_carry_i,
  output logic [DATA_WIDTH-1:0]           acc_o,
  output logic [ADDR_WIDTH-1:0]           pc_o,
  output logic                            carry_o,
  output logic                            zero_o,
  output logic                            halted_o
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
  logic [DATA_WIDTH-1:0]   opnd_q, opnd_d;
  logic                    carry_q, carry_d;
  logic                    zero_q, zero_d;
  // Cleared by reset and set one cycle later, so the bus stays idle in the
  // cycle after a reset edge even though the state is already FETCH.
  logic                    run_q;

  logic [OPC_W-1:0]        opcode;
  logic [ADDR_WIDTH-1:0]   operand;
  logic                    xfer;
  logic                    jump_taken;

  logic                    dec_needs_operand;
  logic                    dec_is_alu;
  logic                    dec_is_load;
  logic                    dec_is_jump;
  logic                    dec_is_store;
  logic                    dec_is_halt;
  logic [OC_W-1:0]         dec_alu_oc;

  assign opcode  = ir_q[INSTR_WIDTH-1 -: OPC_W];
  assign operand = ir_q[ADDR_WIDTH-1:0];

  instr_decoder u_decoder (
    .opcode_i        (opcode),
    .needs_operand_o (dec_needs_operand),
    .is_alu_o        (dec_is_alu),
    .is_load_o       (dec_is_load),
    .is_jump_o       (dec_is_jump),
    .is_store_o      (dec_is_store),
    .is_halt_o       (dec_is_halt),
    .alu_oc_o        (dec_alu_oc)
  );

  // Bus controls decode registered state only; mem_ready_i never feeds them.
  assign mem_req_o   = run_q && ((state_q == FETCH) || (state_q == OPERAND) ||
                                 (state_q == STORE));
  assign mem_we_o    = (state_q == STORE);
  assign mem_addr_o  = (state_q == FETCH) ? pc_q : operand;
  assign mem_wdata_o = {{(INSTR_WIDTH-DATA_WIDTH){1'b0}}, acc_q};
  assign xfer        = mem_req_o && mem_ready_i;

  assign alu_a_o  = acc_q;
  assign acc_o    = acc_q;
  assign pc_o     = pc_q;
  assign carry_o  = carry_q;
  assign zero_o   = zero_q;
  assign halted_o = (state_q == HALT);

  // Conditional jumps test the flags left by the last ALU op or LOAD.
  always_comb begin
    jump_taken = 1'b0;
    unique case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = zero_q;
      OP_JC:   jump_taken = carry_q;
      default: jump_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FETCH;
      pc_q    <= '0;
      acc_q   <= '0;
      ir_q    <= '0;
      opnd_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      opnd_q  <= opnd_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    ir_d     = ir_q;
    opnd_d   = opnd_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    alu_b_o  = '0;
    alu_oc_o = '0;

    unique case (state_q)
      FETCH: begin
        if (xfer) begin
          ir_d    = mem_rdata_i;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = DECODE;
        end
      end

      DECODE: begin
        if (dec_is_halt) begin
          state_d = HALT;
        end else if (dec_needs_operand) begin
          state_d = OPERAND;
        end else if (dec_is_store) begin
          state_d = STORE;
        end else if (dec_is_alu) begin
          state_d = EXECUTE;
        end else begin
          if (dec_is_jump && jump_taken) begin
            pc_d = operand;
          end
          state_d = FETCH;
        end
      end

      OPERAND: begin
        if (xfer) begin
          opnd_d  = mem_rdata_i[DATA_WIDTH-1:0];
          state_d = EXECUTE;
        end
      end

      EXECUTE: begin
        if (dec_is_alu) begin
          alu_oc_o = OPERATION_CODE_WIDTH'(dec_alu_oc);
          alu_b_o  = dec_needs_operand ? opnd_q : DATA_WIDTH'(1);
          acc_d    = alu_result_i;
          carry_d  = alu_carry_i;
          zero_d   = (alu_result_i == '0);
        end else if (dec_is_load) begin
          acc_d  = opnd_q;
          zero_d = (opnd_q == '0);
        end
        state_d = FETCH;
      end

      STORE: begin
        if (xfer) begin
          state_d = FETCH;
        end
      end

      HALT: state_d = HALT;

      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       mem_req, mem_we, mem_ready;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_oc;
  logic       alu_carry;
  logic [3:0] acc, pc;
  logic       carry, zero, halted;

  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ready_i  (mem_ready),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_oc_o     (alu_oc),
    .alu_result_i (alu_result),
    .alu_carry_i  (alu_carry),
    .acc_o        (acc),
    .pc_o         (pc),
    .carry_o      (carry),
    .zero_o       (zero),
    .halted_o     (halted)
  );

  // Reference alu: carry out on add, borrow on subtract, 0 for logic ops.
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum    = 5'd0;
    alu_result = alu_a;
    alu_carry  = 1'b0;
    case (alu_oc)
      3'b001: alu_result = alu_a ^ alu_b;
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100, 3'b101: begin
        alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_sum[3:0];
        alu_carry  = alu_sum[4];
      end
      3'b110, 3'b111: begin
        alu_sum    = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = alu_sum[3:0];
        alu_carry  = alu_sum[4];
      end
      default: ;
    endcase
  end

  // Memory: image loaded while reset is low; wait_n wait cycles per transfer.
  logic [7:0] mem [16];
  logic [7:0] img [16];
  int         wait_n = 0;
  int         wait_ctr = 0;
  int         cyc = 0;

  assign mem_ready = (wait_ctr >= wait_n);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) mem[i] <= img[i];
      wait_ctr <= 0;
    end else if (mem_req) begin
      if (mem_ready) begin
        wait_ctr <= 0;
        if (mem_we) mem[mem_addr] <= mem_wdata;
      end else begin
        wait_ctr <= wait_ctr + 1;
      end
    end
  end

  // Scoreboard of expected bus transfers with the architectural state that
  // must be visible while each one is on the bus.
  typedef struct {
    bit         fetch;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [3:0] acc;
    bit         c;
    bit         z;
    int         gap;  // cycles since previous fetch completed, 0 = unchecked
  } item_t;

  item_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    last_fetch = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit f, input bit w, input logic [3:0] a, input logic [7:0] wd,
                      input logic [3:0] ac, input bit c, input bit z, input int gap);
    item_t e;
    e.fetch = f; e.we = w; e.addr = a; e.wdata = wd;
    e.acc = ac; e.c = c; e.z = z; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic fx(input logic [3:0] a, input logic [3:0] ac, input bit c, input bit z,
                    input int gap);
    push(1'b1, 1'b0, a, 8'h00, ac, c, z, gap);
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] ac, input bit c, input bit z);
    push(1'b0, 1'b0, a, 8'h00, ac, c, z, 0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] wd, input logic [3:0] ac,
                    input bit c, input bit z);
    push(1'b0, 1'b1, a, wd, ac, c, z, 0);
  endtask

  // Monitor: checks every cycle the DUT requests the bus, pops on completion.
  always @(negedge clk) begin
    item_t e;
    if (!rst_ni) begin
      last_fetch = -1;
    end else if (mem_req) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_req", {28'd0, mem_addr}, 32'hFFFF);
      end else begin
        e = exp_q[0];
        chk("bus_addr", mem_addr, e.addr);
        chk("bus_we", mem_we, e.we);
        if (e.we) chk("bus_wdata", mem_wdata, e.wdata);
        chk("acc", acc, e.acc);
        chk("carry", carry, e.c);
        chk("zero", zero, e.z);
        if (mem_ready) begin
          e = exp_q.pop_front();
          if (e.fetch) begin
            if (e.gap != 0) chk("fetch_gap", cyc - last_fetch, e.gap);
            last_fetch = cyc;
          end
        end
      end
    end
  end

  task automatic set_img(input logic [7:0] v [16]);
    for (int i = 0; i < 16; i++) img[i] = v[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_ni = 1'b0;
    @(posedge clk);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 1);
    chk("rst_halted", halted, 0);
  endtask

  task automatic start();
    rst_ni = 1'b1;
  endtask

  task automatic wait_halt(input int halt_gap, input logic [3:0] exp_pc,
                           input logic [3:0] exp_acc);
    int n;
    n = 0;
    @(negedge clk);
    while (halted !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (halted !== 1'b1) begin
      chk("halt_timeout", halted, 1);
    end else begin
      chk("halt_latency", cyc - last_fetch, halt_gap);
      repeat (2) @(negedge clk);
      chk("halt_stays", halted, 1);
      chk("halt_no_req", mem_req, 0);
      chk("halt_pc", pc, exp_pc);
      chk("halt_acc", acc, exp_acc);
    end
    chk("queue_left", exp_q.size(), 0);
  endtask

  logic [7:0] p [16];

  initial begin
    rst_ni = 1'b0;
    for (int i = 0; i < 16; i++) p[i] = 8'hF0;

    // Test 1: LOAD 5, ADD 4, STORE 6, HALT (store kept off the program).
    p[0] = 8'h85; p[1] = 8'h44; p[2] = 8'h96; p[3] = 8'hF0; p[4] = 8'h00; p[5] = 8'h03;
    p[6] = 8'h00;
    set_img(p);
    wait_n = 0;
    do_reset();
    fx(0, 4'h0, 0, 1, 0); rd(5, 4'h0, 0, 1);
    fx(1, 4'h3, 0, 0, 4); rd(4, 4'h3, 0, 0);
    fx(2, 4'h3, 0, 0, 4); wr(6, 8'h03, 4'h3, 0, 0);
    fx(3, 4'h3, 0, 0, 3);
    start();
    wait_halt(2, 4'h4, 4'h3);
    chk("store_mem6", mem[6], 8'h03);
    chk("mem3_intact", mem[3], 8'hF0);

    // Test 2: ADD1 on 0xF sets carry/zero, JC taken to 8.
    for (int i = 0; i < 16; i++) p[i] = 8'hF0;
    p[0] = 8'h8A; p[1] = 8'h50; p[2] = 8'hC8; p[10] = 8'h0F;
    set_img(p);
    do_reset();
    fx(0, 4'h0, 0, 1, 0); rd(10, 4'h0, 0, 1);
    fx(1, 4'hF, 0, 0, 4);
    fx(2, 4'h0, 1, 1, 3);
    fx(8, 4'h0, 1, 1, 2);
    start();
    wait_halt(2, 4'h9, 4'h0);
    chk("t2_carry", carry, 1);

    // Test 3: SUB1 to zero, JZ taken to 2; ADD1, JZ not taken.
    for (int i = 0; i < 16; i++) p[i] = 8'hF0;
    p[0] = 8'h8E; p[1] = 8'hA5; p[2] = 8'h50; p[3] = 8'hB9; p[4] = 8'hF0;
    p[5] = 8'h60; p[6] = 8'hB2; p[14] = 8'h01;
    set_img(p);
    do_reset();
    fx(0, 4'h0, 0, 1, 0); rd(14, 4'h0, 0, 1);
    fx(1, 4'h1, 0, 0, 4);
    fx(5, 4'h1, 0, 0, 2);
    fx(6, 4'h0, 0, 1, 3);
    fx(2, 4'h0, 0, 1, 2);
    fx(3, 4'h1, 0, 0, 3);
    fx(4, 4'h1, 0, 0, 2);
    start();
    wait_halt(2, 4'h5, 4'h1);

    // Test 4: three wait cycles on every transfer.
    for (int i = 0; i < 16; i++) p[i] = 8'hF0;
    p[0] = 8'h8A; p[1] = 8'hF0; p[10] = 8'h07;
    set_img(p);
    wait_n = 3;
    do_reset();
    fx(0, 4'h0, 0, 1, 0); rd(10, 4'h0, 0, 1);
    fx(1, 4'h7, 0, 0, 10);
    start();
    wait_halt(2, 4'h2, 4'h7);

    // Test 5: reset while the operand read is stalled, then restart.
    do_reset();
    fx(0, 4'h0, 0, 1, 0); rd(10, 4'h0, 0, 1);
    start();
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!(mem_req === 1'b1 && mem_addr === 4'hA && mem_ready === 1'b0) && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t5_reached_operand_wait", n < 50, 1);
    end
    do_reset();
    wait_n = 0;
    fx(0, 4'h0, 0, 1, 0); rd(10, 4'h0, 0, 1);
    fx(1, 4'h7, 0, 0, 4);
    start();
    wait_halt(2, 4'h2, 4'h7);

    // Test 6: JMP to 15, pc wraps to 0; XOR/AND/OR of 0x6 with 0xA.
    for (int i = 0; i < 16; i++) p[i] = 8'hF0;
    p[0] = 8'hB6; p[1] = 8'h8D; p[2] = 8'h2E; p[3] = 8'h8D; p[4] = 8'h3E;
    p[5] = 8'hF0; p[6] = 8'h8D; p[7] = 8'hAF; p[15] = 8'h1E;
    p[13] = 8'h06; p[14] = 8'h0A;
    set_img(p);
    do_reset();
    fx(0, 4'h0, 0, 1, 0);
    fx(6, 4'h0, 0, 1, 2); rd(13, 4'h0, 0, 1);
    fx(7, 4'h6, 0, 0, 4);
    fx(15, 4'h6, 0, 0, 2); rd(14, 4'h6, 0, 0);
    fx(0, 4'hC, 0, 0, 4);
    fx(1, 4'hC, 0, 0, 2); rd(13, 4'hC, 0, 0);
    fx(2, 4'h6, 0, 0, 4); rd(14, 4'h6, 0, 0);
    fx(3, 4'h2, 0, 0, 4); rd(13, 4'h2, 0, 0);
    fx(4, 4'h6, 0, 0, 4); rd(14, 4'h6, 0, 0);
    fx(5, 4'hE, 0, 0, 4);
    start();
    wait_halt(2, 4'h6, 4'hE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
